// File: rtl/serializer_sched_if.sv
// serializer_sched_if: request handshakes and serial/mux outputs of the 16:1 serializer scheduler.
interface serializer_sched_if #(parameter int N = 15);
    logic         req0_valid;
    logic [N:0]   req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [N:0]   req1_data;
    logic         req1_ready;
    logic [N:0]   word;
    logic [3:0]   sel;
    logic         ser_bit;
    logic         bit_valid;
    logic         frame_start;
    logic         frame_last;
    logic         grant_id;
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, word, sel, ser_bit, bit_valid, frame_start, frame_last, grant_id
    );
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, word, sel, ser_bit, bit_valid, frame_start, frame_last, grant_id
    );
endinterface

// File: rtl/serializer_sched.sv
// serializer_sched: round-robin two-requester scheduler stepping a 16:1 mux select LSB first.
// Define SER_PARITY_EN to append an even-parity bit (PARITY state) to every frame.
module serializer_sched #(parameter int N = 15) (
    input logic clk,
    input logic rst_n,
    serializer_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    state_t     state, state_nxt;
    logic [N:0] word_q;
    logic [3:0] sel_q;
    logic       grant_q, last_grant, pick, accept, idle, last_bit;
    always_comb begin
        idle = state == IDLE;
        // a lone valid wins outright; otherwise point at the requester not served last
        pick = (bus.req0_valid && !bus.req1_valid) ? 1'b0 :
               (bus.req1_valid && !bus.req0_valid) ? 1'b1 : ~last_grant;
        bus.req0_ready = rst_n && idle && !pick;
        bus.req1_ready = rst_n && idle && pick;
        accept = idle && (pick ? bus.req1_valid : bus.req0_valid);
        last_bit = state == SHIFT && sel_q == 4'd15;
`ifdef SER_PARITY_EN
        state_nxt = accept ? SHIFT : last_bit ? PARITY : state == PARITY ? IDLE : state;
        bus.ser_bit = state == SHIFT ? word_q[sel_q] : state == PARITY ? ^word_q : 1'b0;
        bus.frame_last = state == PARITY;
`else
        state_nxt = accept ? SHIFT : last_bit ? IDLE : state;
        bus.ser_bit = state == SHIFT ? word_q[sel_q] : 1'b0;
        bus.frame_last = last_bit;
`endif
        bus.bit_valid = !idle;
        bus.frame_start = state == SHIFT && sel_q == 4'd0;
        bus.word = word_q;
        bus.sel = sel_q;
        bus.grant_id = grant_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            word_q <= '0;
            sel_q <= '0;
            grant_q <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word_q <= pick ? bus.req1_data : bus.req0_data;
                sel_q <= '0;
                grant_q <= pick;
                last_grant <= pick;
            end else if (state == SHIFT && sel_q != 4'd15) begin
                sel_q <= sel_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_serializer_sched.sv
// tb_serializer_sched: scoreboard bench; a reference arbiter pushes expected bits on each accept.
module tb_serializer_sched;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 17 : 16;
    localparam int PERIOD = FL + 1;
    typedef struct {
        logic       b;
        logic       fs;
        logic       fl;
        logic       g;
        logic [3:0] s;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    serializer_sched_if bus ();
    serializer_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    exp_t q[$];
    logic gq[$];
    int checks = 0, failures = 0;
    int rem = 0, acc0 = 0, acc1 = 0, cyc = 0, last_fs = -1;
    logic m_last = 1'b1;
    bit spacing_on = 1'b0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic push_frame(input logic g, input logic [15:0] d);
        for (int i = 0; i < 16; i++) q.push_back(exp_t'{d[i], i == 0, (i == 15) && !PAR, g, 4'(i)});
        if (PAR) q.push_back(exp_t'{^d, 1'b0, 1'b1, g, 4'd15});
    endtask
    initial begin : mon
        exp_t e;
        logic p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                rem = 0;
                m_last = 1'b1;
            end else begin
                check("bit_valid", bus.bit_valid, rem > 0);
                if (bus.bit_valid) begin
                    if (q.size() == 0) check("unexpected_bit", 1, 0);
                    else begin
                        e = q.pop_front();
                        check("ser_bit", bus.ser_bit, e.b);
                        check("sel", bus.sel, e.s);
                        check("frame_start", bus.frame_start, e.fs);
                        check("frame_last", bus.frame_last, e.fl);
                        check("grant_id", bus.grant_id, e.g);
                    end
                end else begin
                    check("idle_outputs", {bus.ser_bit, bus.frame_start, bus.frame_last}, 3'b000);
                end
                if (bus.frame_start && spacing_on) begin
                    if (last_fs >= 0) check("frame_spacing", cyc - last_fs, PERIOD);
                    last_fs = cyc;
                    gq.push_back(bus.grant_id);
                end
                if (rem > 0) begin
                    check("busy_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
                    rem--;
                end else begin
                    p = (bus.req0_valid && !bus.req1_valid) ? 1'b0 :
                        (bus.req1_valid && !bus.req0_valid) ? 1'b1 : ~m_last;
                    check("idle_ready", {bus.req0_ready, bus.req1_ready}, {!p, p});
                    if (p ? bus.req1_valid : bus.req0_valid) begin
                        push_frame(p, p ? bus.req1_data : bus.req0_data);
                        rem = FL;
                        m_last = p;
                        if (p) acc1++; else acc0++;
                    end
                end
            end
        end
    end
    task automatic send(input logic id, input logic [15:0] d);
        int a;
        @(posedge clk); #1;
        a = acc0 + acc1;
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
        else begin bus.req0_valid = 1'b1; bus.req0_data = d; end
        for (int i = 0; i < 80 && acc0 + acc1 == a; i++) begin @(posedge clk); #1; end
        if (acc0 + acc1 == a) check("accept_timeout", 0, 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask
    task automatic drain();
        int i;
        for (i = 0; i < 100 && (rem > 0 || q.size() > 0); i++) begin @(posedge clk); #1; end
        if (rem > 0 || q.size() > 0) check("drain_timeout", 0, 1);
    endtask
    initial begin
        int a;
        bit found;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_data = 16'h1234;
        bus.req1_data = 16'h0;
        #1;
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_outputs", {bus.bit_valid, bus.ser_bit, bus.frame_start, bus.frame_last, bus.grant_id}, 5'b0);
        check("rst_word", bus.word, 16'h0);
        check("rst_sel", bus.sel, 4'd0);
        bus.req0_valid = 1'b0;
        #20 rst_n = 1'b1;
        // tie burst straight out of reset: grants must go 0,1,0,1 at fixed spacing
        @(posedge clk); #1;
        spacing_on = 1'b1;
        last_fs = -1;
        a = acc0 + acc1;
        bus.req0_data = 16'h0001;
        bus.req1_data = 16'h8000;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && acc0 + acc1 < a + 4; i++) begin @(posedge clk); #1; end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();
        spacing_on = 1'b0;
        check("burst_frames", gq.size(), 4);
        for (int i = 0; i < gq.size(); i++) check("burst_grant", gq[i], i % 2);
        send(1'b1, 16'h3C5A);
        drain();
        send(1'b0, 16'hA5C3);
        drain();
        send(1'b0, 16'h0007);
        drain();
        send(1'b1, 16'h0003);
        drain();
        send(1'b0, 16'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = bus.bit_valid && bus.sel == 4'd7;
        end
        check("reach_sel7", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_bit_valid", bus.bit_valid, 1'b0);
        check("abort_outputs", {bus.ser_bit, bus.frame_start, bus.frame_last, bus.grant_id}, 4'b0);
        check("abort_word", bus.word, 16'h0);
        check("abort_sel", bus.sel, 4'd0);
        check("abort_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        a = acc0;
        bus.req0_data = 16'h00F0;
        bus.req1_data = 16'h0F00;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 10 && acc0 + acc1 == a + acc1; i++) begin @(posedge clk); #1; end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("tie_after_reset", acc0, a + 1);
        check("restart_grant", bus.grant_id, 1'b0);
        check("restart_sel", bus.sel, 4'd0);
        drain();
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
